// File: rtl/dmem_mmio_responder_if.sv
// Bundles the CPU data-memory port with the TX stream toward the external consumer.
interface dmem_mmio_responder_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output daddr, dwdata, dwe, tx_ready,
        input  drdata, tx_data, tx_valid
    );

    modport slave (
        input  daddr, dwdata, dwe, tx_ready,
        output drdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: byte-lane RAM plus an MMIO window holding a cycle
// counter, a TX FIFO drained over valid/ready, and a status register.
module dmem_mmio_responder #(
    parameter int unsigned RAM_WORDS  = 128,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_wordAddr;
    logic          w_isRam;
    logic          w_isCycle;
    logic          w_isTx;
    logic          w_isStatus;
    logic          w_pushReq;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ovfSet;
    logic          w_ovfClr;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused;

    logic [7:0]    r_mem0 [RAM_WORDS];
    logic [7:0]    r_mem1 [RAM_WORDS];
    logic [7:0]    r_mem2 [RAM_WORDS];
    logic [7:0]    r_mem3 [RAM_WORDS];
    logic [31:0]   r_buf  [FIFO_DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_cycle;

    assign w_idx      = bus.daddr[AW+1:2];
    assign w_wordAddr = {bus.daddr[31:2], 2'b00};
    assign w_isRam    = (bus.daddr[31:9] == 23'd0);
    assign w_isCycle  = (w_wordAddr == MMIO_BASE);
    assign w_isTx     = (w_wordAddr == MMIO_BASE + 32'd4);
    assign w_isStatus = (w_wordAddr == MMIO_BASE + 32'd8);
    assign w_unused   = ^bus.daddr[1:0];

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.tx_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pushReq = w_isTx && (bus.dwe == 4'hF);
    assign w_push    = reset && w_pushReq && (!w_full || w_pop);
    assign w_ovfSet  = w_pushReq && w_full && !w_pop;
    assign w_ovfClr  = w_isStatus && bus.dwe[2] && bus.dwdata[16];

    assign bus.tx_data  = r_buf[r_rdPtr];
    assign bus.tx_valid = !w_empty;
    assign bus.drdata   = w_rdata;

    always_ff @(posedge clk) begin
        if (w_isRam) begin
            if (bus.dwe[0]) r_mem0[w_idx] <= bus.dwdata[7:0];
            if (bus.dwe[1]) r_mem1[w_idx] <= bus.dwdata[15:8];
            if (bus.dwe[2]) r_mem2[w_idx] <= bus.dwdata[23:16];
            if (bus.dwe[3]) r_mem3[w_idx] <= bus.dwdata[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wrPtr] <= bus.dwdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // Clearing has priority over a drop in the same cycle.
            if (w_ovfClr) begin
                r_overflow <= 1'b0;
            end else if (w_ovfSet) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_status      = '0;
        w_status[4:0] = 5'(r_count);
        w_status[8]   = w_empty;
        w_status[9]   = w_full;
        w_status[16]  = r_overflow;
    end

    always_comb begin
        w_rdata = '0;
        if (w_isRam) begin
            w_rdata = {r_mem3[w_idx], r_mem2[w_idx], r_mem1[w_idx], r_mem0[w_idx]};
        end else if (w_isCycle) begin
            w_rdata = r_cycle;
        end else if (w_isStatus) begin
            w_rdata = w_status;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: directed and random CPU traffic checked
// against a transaction-level model of the RAM, CYCLE, STATUS and TX queue.
module tb_dmem_mmio_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_WORDS (128),
        .FIFO_DEPTH(DEPTH),
        .MMIO_BASE (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] expQ[$];
    logic [7:0]  ramB [4][128];
    bit          ramKnown [4][128];
    logic        mOvf = 1'b0;
    logic [31:0] mCycle = '0;
    logic        rdyNow = 1'b0;
    logic        rstNow = 1'b0;
    int          sizeBefore;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, got, want);
        end
    endtask

    function automatic logic [31:0] statusWord();
        int n = expQ.size();
        return 32'(n) + ((n == 0) ? 32'h100 : 32'h0) + ((n == DEPTH) ? 32'h200 : 32'h0)
               + (mOvf ? 32'h1_0000 : 32'h0);
    endfunction

    // Expected load value; mask hides RAM bytes never written by the bench.
    function automatic void modelRead(input logic [31:0] addr, output logic [31:0] val,
                                      output logic [31:0] mask);
        int idx;
        val  = '0;
        mask = 32'hFFFF_FFFF;
        if (addr[31:9] == 23'd0) begin
            idx = int'(addr[8:2]);
            for (int k = 0; k < 4; k++) begin
                if (ramKnown[k][idx]) val[8*k +: 8] = ramB[k][idx];
                else                  mask[8*k +: 8] = 8'h00;
            end
        end else if ({addr[31:2], 2'b00} == BASE) begin
            val = mCycle;
        end else if ({addr[31:2], 2'b00} == BASE + 32'd8) begin
            val = statusWord();
        end
    endfunction

    // One bus cycle, entered and left on a falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
        logic [31:0] expVal;
        logic [31:0] mask;
        logic [31:0] word;
        int          idx;
        bit          popNow;
        bus.daddr    = addr;
        bus.dwdata   = wdata;
        bus.dwe      = we;
        bus.tx_ready = rdyNow;
        reset        = rstNow;
        #1;
        modelRead(addr, expVal, mask);
        if (mask != 32'd0) checkOutput($sformatf("drdata@%08h", addr), bus.drdata & mask, expVal & mask);
        sizeBefore = expQ.size();
        popNow     = (sizeBefore > 0) && rdyNow && rstNow;
        @(posedge clk);
        word = {addr[31:2], 2'b00};
        if (addr[31:9] == 23'd0) begin
            idx = int'(addr[8:2]);
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    ramB[k][idx]     = wdata[8*k +: 8];
                    ramKnown[k][idx] = 1'b1;
                end
            end
        end
        if (!rstNow) begin
            expQ.delete();
            mOvf   = 1'b0;
            mCycle = '0;
        end else begin
            mCycle = mCycle + 32'd1;
            if (word == BASE + 32'd4 && we == 4'hF) begin
                if (sizeBefore < DEPTH || popNow) expQ.push_back(wdata);
                else                              mOvf = 1'b1;
            end
            if (word == BASE + 32'd8 && we[2] && wdata[16]) mOvf = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: checks tx_valid every active cycle and pops the scoreboard on handshakes.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (rstNow) begin
                checkOutput("tx_valid", 32'(bus.tx_valid), (expQ.size() != 0) ? 32'd1 : 32'd0);
                if (expQ.size() != 0) begin
                    checkOutput("tx_data", bus.tx_data, expQ[0]);
                    if (bus.tx_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        bus.daddr    = '0;
        bus.dwdata   = '0;
        bus.dwe      = '0;
        bus.tx_ready = 1'b0;
        reset        = 1'b0;
        @(negedge clk);

        rstNow = 1'b0;
        applyStimulus(32'h0, 32'h0, 4'h0);
        applyStimulus(32'h0, 32'h0, 4'h0);
        rstNow = 1'b1;
        applyStimulus(BASE, 32'h0, 4'h0);

        // RAM byte lanes
        applyStimulus(32'h10, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(32'h10, 32'h0000_5500, 4'b0010);
        applyStimulus(32'h13, 32'h0, 4'h0);
        checkOutput("mem1_idx4", {24'h0, dut.r_mem1[4]}, 32'h0000_0055);
        checkOutput("ram_lane_merge", bus.drdata, 32'hDEAD_55EF);

        // CYCLE restart and wrap
        rstNow = 1'b0;
        applyStimulus(BASE, 32'h0, 4'h0);
        rstNow = 1'b1;
        repeat (5) applyStimulus(BASE + 32'h40, 32'h0, 4'h0);
        applyStimulus(BASE, 32'h1234_5678, 4'hF);
        bus.daddr = BASE;
        bus.dwe   = 4'h0;
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        checkOutput("cycle_forced", bus.drdata, 32'hFFFF_FFFF);
        release dut.r_cycle;
        @(posedge clk);
        mCycle = 32'hFFFF_FFFF;
        mCycle = mCycle + 32'd1;
        @(negedge clk);
        applyStimulus(BASE, 32'h0, 4'h0);

        // FIFO order and drain
        rdyNow = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(BASE + 32'd4, 32'(i), 4'hF);
        applyStimulus(BASE + 32'd8, 32'h0, 4'h0);
        rdyNow = 1'b1;
        repeat (4) applyStimulus(BASE + 32'd8, 32'h0, 4'h0);

        // Full, overflow and clear
        rdyNow = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(BASE + 32'd4, 32'h100 + 32'(i), 4'hF);
        applyStimulus(BASE + 32'd8, 32'h0, 4'h0);
        applyStimulus(BASE + 32'd8, 32'h0001_0000, 4'b0100);
        applyStimulus(BASE + 32'd8, 32'h0, 4'h0);

        // Push and pop together while full
        rdyNow = 1'b1;
        applyStimulus(BASE + 32'd4, 32'h0000_00A5, 4'hF);
        repeat (10) applyStimulus(BASE + 32'd8, 32'h0, 4'h0);

        // Reset mid-drain, partial TX store, unmapped read
        rdyNow = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(BASE + 32'd4, 32'h200 + 32'(i), 4'hF);
        rstNow = 1'b0;
        applyStimulus(BASE + 32'd4, 32'h0000_0BAD, 4'hF);
        rstNow = 1'b1;
        applyStimulus(BASE, 32'h0, 4'h0);
        applyStimulus(BASE + 32'd8, 32'h0, 4'h0);
        applyStimulus(BASE + 32'd4, 32'h0000_0077, 4'b0011);
        applyStimulus(BASE + 32'd8, 32'h0, 4'h0);
        applyStimulus(32'h4000_0000, 32'h0, 4'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rdyNow = ($urandom_range(0, 2) != 0);
            rstNow = ($urandom_range(0, 79) != 0);
            d = $urandom;
            w = 4'h0;
            case ($urandom_range(0, 9))
                0: begin
                    a = {23'd0, 7'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                    w = 4'($urandom_range(0, 15));
                end
                1, 2: a = {23'd0, 7'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                3, 4: begin
                    a = BASE + 32'd4 + 32'($urandom_range(0, 3));
                    w = 4'hF;
                end
                5: begin
                    a = BASE + 32'd4;
                    w = 4'($urandom_range(1, 14));
                end
                6: a = BASE + 32'd8 + 32'($urandom_range(0, 3));
                7: begin
                    a = BASE + 32'd8;
                    w = 4'($urandom_range(0, 15));
                end
                8: begin
                    a = BASE + 32'($urandom_range(0, 3));
                    w = 4'($urandom_range(0, 15));
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = BASE + 32'd12;
                        1:       a = BASE + 32'h100;
                        2:       a = 32'h0000_0200 + 32'($urandom_range(0, 255));
                        default: a = 32'h4000_0000;
                    endcase
                    w = 4'($urandom_range(0, 15));
                end
            endcase
            applyStimulus(a, d, w);
        end

        rstNow = 1'b1;
        rdyNow = 1'b1;
        repeat (12) applyStimulus(BASE + 32'd8, 32'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder end of the CPU data-memory port (daddr/drdata/dwdata/dwe). It serves the CPU's loads and stores from a byte-lane RAM and a small MMIO window. The window holds a free-running cycle counter, a TX FIFO that drains to an external consumer over a valid/ready handshake, and a status register. The block sits beside imem and replaces a plain dmem when a program must emit results or read time.

Parameters:
RAM_WORDS, 128, number of 32-bit RAM words; word index is daddr[log2(RAM_WORDS)+1:2].
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2.
MMIO_BASE, 32'h8000_0000, base address of the MMIO window.

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clk.
daddr  input  32  byte address from the CPU.
dwdata  input  32  store data from the CPU.
dwe  input  4  byte write enables; dwe[k] writes byte k (dwdata[8k+7:8k]).
drdata  output  32  load data; combinational from daddr and current state.
tx_data  output  32  head entry of the TX FIFO.
tx_valid  output  1  high when the FIFO is non-empty.
tx_ready  input  1  consumer accepts the head on a cycle where tx_valid && tx_ready.

Behaviour:
- Decode:
  - RAM when daddr[31:9]==0.
  - CYCLE at MMIO_BASE+0.
  - TX at MMIO_BASE+4.
  - STATUS at MMIO_BASE+8.
  - Anything else is unmapped: reads return 0, writes are ignored.
  - daddr[1:0] is ignored everywhere.
- RAM:
  - Four byte-lane arrays, mem0..mem3, with mem0 = byte 0.
  - Writes are synchronous, per lane, gated by dwe.
  - Reads are combinational: {mem3,mem2,mem1,mem0}[idx]. A same-cycle read returns the old data.
  - Contents are not affected by reset.
- CYCLE (read-only):
  - 32-bit counter. Reads 0 on the first cycle after reset deasserts, then +1 per clk.
  - Wraps 32'hFFFF_FFFF to 0.
  - Writes are ignored.
- TX (write-only, reads 0):
  - A store with dwe==4'hF pushes dwdata. Partial dwe (not 0, not F) is ignored.
  - A push while the FIFO is full and no pop occurs that cycle is dropped and sets the sticky overflow flag.
- STATUS (read):
  - [4:0] count (0..FIFO_DEPTH).
  - [8] empty.
  - [9] full.
  - [16] overflow.
  - All other bits read 0.
  - A write with dwe[2]=1 and dwdata[16]=1 clears overflow. Set and clear in the same cycle: clear wins.
- FIFO:
  - Circular buffer, depth FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap. count is a separate register.
  - Pop happens when tx_valid && tx_ready.
  - tx_data = buf[rd_ptr]; tx_valid = (count != 0). Both are valid in the cycle after the push edge; a push is never bypassed to the output in the same cycle.
  - Push and pop in the same cycle with count==FIFO_DEPTH: both happen, count stays FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle with 0 < count < FIFO_DEPTH: both happen, count is unchanged.
  - Push with count==0: count becomes 1. tx_ready is ignored because tx_valid was 0.
- Reset (reset==0 at posedge):
  - CYCLE=0, rd_ptr=wr_ptr=0, count=0, overflow=0.
  - tx_valid=0 on the following cycle; tx_data is don't-care while tx_valid=0.
  - A reset mid-drain discards all FIFO entries.
  - drdata stays combinational: 0 for MMIO-empty reads, RAM data for RAM reads.
  - Pushes presented during reset are ignored.
- Latency: loads 0 cycles; stores and pushes are visible on the next cycle.

Test Plan:
1. RAM lanes: store 32'hDEADBEEF at 0x10 with dwe=F, then dwe=4'b0010 with dwdata=32'h0000_5500 -> load 0x10 returns 32'hDEAD55EF; mem1[4]==8'h55.
2. CYCLE: deassert reset, read CYCLE 5 cycles later -> 5. Force the counter to 32'hFFFF_FFFF -> reads 0 one cycle later.
3. FIFO order and drain:
   - Push 1,2,3 with tx_ready=0 -> STATUS[4:0]=3, tx_data=1.
   - Raise tx_ready -> tx_data sequence 1,2,3, then tx_valid=0 and STATUS=32'h0000_0100.
4. Full and overflow:
   - Push 9 words with tx_ready=0 -> 9th dropped; STATUS=32'h0001_0208; head is still word 1.
   - Write STATUS with dwdata=32'h0001_0000, dwe=4'b0100 -> STATUS=32'h0000_0208.
5. Full with simultaneous push and pop: at count=8, push 32'hA5 while tx_ready=1 -> count stays 8, no overflow, 32'hA5 is the last word out.
6. Reset mid-operation:
   - With count=4, assert reset for one cycle -> tx_valid=0, STATUS=32'h0000_0100, CYCLE restarts at 0.
   - A partial-dwe write to TX -> no push.
   - An unmapped address -> reads 0.
